// File: rtl/key_cursor_pkg.sv
// Shared constants and types for the key-driven cursor drawing block.
// Grid geometry, pixel-buffer address width, FSM states, key bit indices.
package key_cursor_pkg;

  localparam int GRID_DIM  = 28;
  localparam int PIX_COUNT = GRID_DIM * GRID_DIM;
  localparam int ADDR_W    = 10;

  localparam int KEY_RIGHT = 3;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_UP    = 1;
  localparam int KEY_DOWN  = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } state_e;

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchronizer, stability counter, and a
// single-cycle press pulse on an accepted high-to-low level change.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 250
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q, sync_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  always_comb begin
    sync_d   = {sync_q[0], key_n};
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync_q[1];
        press_d  = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/key_cursor_ctrl.sv
// Moves a cursor over a square grid from four debounced keys, inks
// the new position when drawing, and sweeps the buffer blank on clear.
module key_cursor_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250,
  parameter int GRID_DIM        = key_cursor_pkg::GRID_DIM
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] key_n,
  input  logic       draw_en,
  input  logic       clear,
  output logic [4:0] cursor_x,
  output logic [4:0] cursor_y,
  output logic       mem_wr_en,
  output logic [9:0] mem_addr,
  output logic       mem_wdata,
  output logic       busy
);

  import key_cursor_pkg::*;

  localparam int         PIX  = GRID_DIM * GRID_DIM;
  localparam logic [4:0] CMAX = 5'(GRID_DIM - 1);

  logic [3:0]        press;
  state_e            state_q, state_d;
  logic [4:0]        x_q, x_d;
  logic [4:0]        y_q, y_d;
  logic [ADDR_W-1:0] clr_q, clr_d;
  logic [ADDR_W-1:0] cur_addr;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clk   (clk),
      .resetn(resetn),
      .key_n (key_n[i]),
      .press (press[i])
    );
  end

  // Opposing presses cancel; moves stop at the grid edges.
  function automatic logic [4:0] step(
    input logic [4:0] v,
    input logic       inc,
    input logic       dec
  );
    step = v;
    if (inc && !dec && v != CMAX)
      step = v + 5'd1;
    else if (dec && !inc && v != 5'd0)
      step = v - 5'd1;
  endfunction

  assign cur_addr = ADDR_W'(y_q) * ADDR_W'(GRID_DIM)
                  + ADDR_W'(x_q);

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    clr_d     = clr_q;
    mem_wr_en = 1'b0;
    mem_wdata = 1'b0;
    mem_addr  = cur_addr;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = CLEAR;
          clr_d   = '0;
        end else if (|press) begin
          x_d = step(x_q, press[KEY_RIGHT], press[KEY_LEFT]);
          y_d = step(y_q, press[KEY_DOWN], press[KEY_UP]);
          if (draw_en)
            state_d = WRITE;
        end
      end
      WRITE: begin
        mem_wr_en = 1'b1;
        mem_wdata = 1'b1;
        state_d   = IDLE;
      end
      CLEAR: begin
        busy      = 1'b1;
        mem_wr_en = 1'b1;
        mem_addr  = clr_q;
        if (clr_q == ADDR_W'(PIX - 1))
          state_d = IDLE;
        else
          clr_d = clr_q + ADDR_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      clr_q   <= clr_d;
    end
  end

  assign cursor_x = x_q;
  assign cursor_y = y_q;

endmodule

// File: tb/tb_key_cursor_ctrl.sv
// Random and directed key/clear stimulus for key_cursor_ctrl,
// compared against a plain arithmetic cursor model.
module tb_key_cursor_ctrl;

  localparam int DB   = 250;
  localparam int GD   = 28;
  localparam int NPIX = GD * GD;

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] key_n;
  logic       draw_en;
  logic       clear;
  logic [4:0] cursor_x;
  logic [4:0] cursor_y;
  logic       mem_wr_en;
  logic [9:0] mem_addr;
  logic       mem_wdata;
  logic       busy;

  int n_chk  = 0;
  int n_fail = 0;
  int mx     = 0;
  int my     = 0;
  int wr_all = 0;
  int wq[$];

  key_cursor_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .GRID_DIM       (GD)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .key_n    (key_n),
    .draw_en  (draw_en),
    .clear    (clear),
    .cursor_x (cursor_x),
    .cursor_y (cursor_y),
    .mem_wr_en(mem_wr_en),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .busy     (busy)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (mem_wr_en) wr_all++;
    if (mem_wr_en && !busy)
      wq.push_back(int'({mem_wdata, mem_addr}));
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clamp(input int v);
    if (v < 0) return 0;
    if (v > GD - 1) return GD - 1;
    return v;
  endfunction

  // mask bits: 3 right, 2 left, 1 up, 0 down
  task automatic press(
    input logic [3:0] mask,
    input bit         de,
    input int         hold
  );
    bit real_press;
    real_press = (hold >= DB + 40);
    wq.delete();
    draw_en = de;
    @(negedge clk);
    key_n = ~mask;
    repeat (hold) @(negedge clk);
    key_n = 4'hF;
    repeat (DB + 50) @(negedge clk);
    if (real_press) begin
      mx = clamp(mx + int'(mask[3]) - int'(mask[2]));
      my = clamp(my + int'(mask[0]) - int'(mask[1]));
    end
    chk("cur_x", cursor_x, mx);
    chk("cur_y", cursor_y, my);
    chk("wr_cnt", wq.size(), (real_press && de) ? 1 : 0);
    if (wq.size() > 0)
      chk("wr_word", wq[0], 1024 + my * GD + mx);
    wq.delete();
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    mx = 0;
    my = 0;
    wq.delete();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_x"}, cursor_x, 0);
    chk({tag, "_y"}, cursor_y, 0);
    chk({tag, "_we"}, mem_wr_en, 0);
    chk({tag, "_wd"}, mem_wdata, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int n;
    int cnt;
    int bad;
    int w0;
    resetn  = 1'b0;
    key_n   = 4'hF;
    draw_en = 1'b0;
    clear   = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outs("rst");

    // press-to-write latency with right held through reset release
    key_n   = 4'b0111;
    draw_en = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    n = 0;
    while (!mem_wr_en && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, DB + 3);
    @(negedge clk);
    key_n = 4'hF;
    repeat (DB + 50) @(negedge clk);
    mx = 1;
    chk("lat_x", cursor_x, 1);
    chk("lat_wr", wq.size(), 1);
    if (wq.size() > 0) chk("lat_word", wq[0], 1024 + 1);
    wq.delete();

    press(4'b1000, 1'b1, 500);
    press(4'b1000, 1'b1, 500);
    chk("three_x", cursor_x, 3);

    w0 = wr_all;
    press(4'b0001, 1'b1, 100);
    chk("glitch_wr", wr_all - w0, 0);

    for (int i = 0; i < 20; i++) begin
      logic [3:0] m;
      m = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 3) == 0)
        press(m, 1'($urandom), $urandom_range(20, 200));
      else
        press(m, 1'($urandom), $urandom_range(300, 600));
    end

    for (int i = 0; i < GD; i++)
      press(4'b1001, 1'b0, DB + 50);
    chk("corner_x", cursor_x, GD - 1);
    chk("corner_y", cursor_y, GD - 1);
    press(4'b1000, 1'b1, DB + 50);
    press(4'b0001, 1'b1, DB + 50);

    // clear sweep with a key press landing mid-sweep
    wq.delete();
    @(negedge clk);
    clear = 1'b1;
    key_n = 4'b1011;
    @(negedge clk);
    clear = 1'b0;
    cnt = 0;
    bad = 0;
    n = 0;
    while (n < 2000) begin
      if (busy) begin
        if (mem_addr != 10'(cnt) || mem_wdata || !mem_wr_en)
          bad++;
        cnt++;
      end else if (cnt > 0) begin
        break;
      end
      if (cnt == DB + 60) key_n = 4'hF;
      @(negedge clk);
      n++;
    end
    key_n = 4'hF;
    chk("clr_len", cnt, NPIX);
    chk("clr_bad", bad, 0);
    chk("clr_done", busy, 0);
    repeat (DB + 50) @(negedge clk);
    chk("clr_x", cursor_x, mx);
    chk("clr_y", cursor_y, my);
    chk("clr_wr", wq.size(), 0);
    wq.delete();

    pulse_reset();
    for (int i = 0; i < 5; i++)
      press(4'b1001, 1'b0, DB + 50);
    w0 = wr_all;
    press(4'b0110, 1'b0, DB + 50);
    chk("lu_x", cursor_x, 4);
    chk("lu_y", cursor_y, 4);
    chk("lu_wr", wr_all - w0, 0);

    // reset in the middle of a sweep
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    n = 0;
    while (!(busy && mem_addr == 10'd400) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("sweep400_reached", n < 2000, 1);
    resetn = 1'b0;
    #1;
    chk_reset_outs("midrst");
    @(negedge clk);
    resetn = 1'b1;
    mx = 0;
    my = 0;
    w0 = wr_all;
    repeat (1000) @(negedge clk);
    chk("post_rst_wr", wr_all - w0, 0);
    chk("post_rst_x", cursor_x, 0);
    chk("post_rst_y", cursor_y, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/key_cursor_ctrl.md
KEY_CURSOR_CTRL -- requirements
Module: key_cursor_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250, meaning the number of consecutive stable synchronized clocks needed to accept a key level change.
REQ-002 SHALL have parameter GRID_DIM, default 28, meaning the drawing grid width and height in pixels.
REQ-003 SHALL have port clk, input, 1 bit: single system clock (CLOCK_50 domain); all logic is clocked on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port key_n, input, 4 bits: raw push-buttons, active-low, asynchronous; bit 3 = right, bit 2 = left, bit 1 = up, bit 0 = down.
REQ-006 SHALL have port draw_en, input, 1 bit: when high, each cursor move writes ink at the new position.
REQ-007 SHALL have port clear, input, 1 bit: a single-cycle request to erase the whole grid.
REQ-008 SHALL have ports cursor_x and cursor_y, outputs, 5 bits each: current cursor column and row, range 0..GRID_DIM-1.
REQ-009 SHALL have port mem_wr_en, output, 1 bit: write strobe to the 784-entry pixel buffer.
REQ-010 SHALL have port mem_addr, output, 10 bits: pixel address, equal to y*GRID_DIM+x.
REQ-011 SHALL have port mem_wdata, output, 1 bit: pixel value (1 = ink, 0 = blank).
REQ-012 SHALL have port busy, output, 1 bit: high while a clear sweep is running.

Function
REQ-013 Each key_n bit SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-014 Per key debounce: a counter increments while the synchronized level differs from the stable level and clears when they match; at DEBOUNCE_CYCLES-1 the stable level flips and the counter clears.
REQ-015 A stable 1->0 transition SHALL emit exactly one 1-cycle press pulse; a release emits no pulse; a held key SHALL NOT auto-repeat.
REQ-016 The FSM SHALL have three states: IDLE, WRITE, CLEAR.
REQ-017 IDLE, on any press pulse: next edge, apply dx=right-left and dy=down-up to the cursor, then go to WRITE if draw_en=1, otherwise stay in IDLE.
REQ-018 Cursor moves SHALL saturate at 0 and GRID_DIM-1 and never wrap; a saturated move still proceeds to WRITE when draw_en=1.
REQ-019 Simultaneous pulses SHALL be applied together: right+left cancels in x, up+down cancels in y, and x and y may both change in one update.
REQ-020 WRITE SHALL last exactly 1 cycle with mem_wr_en=1, mem_wdata=1 and mem_addr from the updated cursor, then return to IDLE; a press-to-write latency of 1 clock after the pulse.
REQ-021 clear=1 in IDLE SHALL take priority over a same-cycle press pulse: the press is dropped, and the next state is CLEAR with address 0.
REQ-022 CLEAR SHALL assert busy=1, mem_wr_en=1 and mem_wdata=0 for 784 consecutive cycles at addresses 0..783 ascending, then return to IDLE with busy=0.
REQ-023 Press pulses arriving in WRITE or CLEAR SHALL be dropped, and the cursor SHALL stay unchanged; clear in WRITE or CLEAR SHALL be ignored.
REQ-024 The cursor SHALL be unaffected by CLEAR.
REQ-025 Outside WRITE and CLEAR, mem_wr_en=0, mem_wdata=0, and mem_addr SHALL track the cursor address.
REQ-026 The mem_addr arithmetic SHALL be computed at 10-bit width with no truncation; the maximum address is 783.

Reset
REQ-027 resetn=0 SHALL immediately force: state IDLE, cursor (0,0), mem_wr_en=0, mem_wdata=0, mem_addr=0, busy=0, synchronizers and stable levels = 1 (released), and debounce counters = 0.
REQ-028 Reset mid-CLEAR or mid-WRITE SHALL abort the operation, with no further writes after release.
REQ-029 After release, keys held low SHALL produce one press only after DEBOUNCE_CYCLES+2 clocks.

Structure
REQ-030 A shared package SHALL hold GRID_DIM, PIX_COUNT=784, ADDR_W=10, the FSM state enum, and the key index constants (KEY_RIGHT=3, KEY_LEFT=2, KEY_UP=1, KEY_DOWN=0).
REQ-031 The synchronizer plus debounce plus press-pulse logic SHALL be one sub-module, key_debounce, instantiated four times.

Verification
REQ-032 With draw_en=1, press KEY[3] for 500 cycles, 3 times -> cursor_x goes 1, 2, 3; three single-cycle writes at addresses 1, 2, 3 with wdata=1.
REQ-033 A 100-cycle low glitch on KEY[0] -> no pulse, cursor unchanged, and mem_wr_en never asserts.
REQ-034 At cursor (27,27), press right then down -> cursor stays (27,27), and two writes occur at address 783.
REQ-035 Pulse clear -> busy=1 for exactly 784 cycles, writes at 0..783 with wdata=0; a key press during the sweep -> ignored.
REQ-036 With draw_en=0, press left and up together from (5,5) -> cursor (4,4) and no write.
REQ-037 Assert resetn=0 at sweep address 400 -> all outputs are at reset values immediately; after release there are no further writes and the cursor is (0,0).
